scan_loader: RTL and testbench
==============================

SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter: BYTES_PER_CHAIN, default 22, bytes per scan chain (one per buffer field).
REQ-002 Parameter: BYTE_WIDTH, default 8, bits per byte.
REQ-003 Parameter: CLK_DIV, default 4, clk cycles per sclk half-period; legal range >= 1.
REQ-004 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: cmd_valid  in  1 / cmd_ready  out  1  transfer-request handshake.
REQ-007 Port: cmd_addr  in  3  chain select, copied to saddr for the whole transfer.
REQ-008 Port: byte_in  in  BYTE_WIDTH / byte_in_valid  in  1 / byte_in_ready  out  1  write-data stream.
REQ-009 Port: byte_out  out  BYTE_WIDTH / byte_out_valid  out  1  readback stream; no backpressure.
REQ-010 Port: busy  out  1  high whenever state is not IDLE.
REQ-011 Port: done  out  1  one-cycle pulse at transfer end.
REQ-012 Port: sclk, sin, ssel  out  1 each; saddr  out  3; sout  in  1  scan-chain master side.

Function
REQ-013 States: IDLE, LOAD, SHIFT, TAIL, DONE.
REQ-014 IDLE: cmd_ready=1. cmd_valid&cmd_ready -> latch cmd_addr, clear byte count, go to LOAD. cmd_ready=0 in all other states; cmd_valid there is ignored.
REQ-015 ssel=1 and saddr=latched address in LOAD, SHIFT and TAIL; otherwise ssel=0 and saddr=0.
REQ-016 LOAD: byte_in_ready=1, sclk=0. On byte_in_valid, load shift register, set sin=byte_in MSB, go to SHIFT. Without byte_in_valid, stay in LOAD indefinitely (chain is static).
REQ-017 SHIFT: each bit is CLK_DIV cycles sclk=0 followed by CLK_DIV cycles sclk=1. Bits are MSB first; one byte takes 2*BYTE_WIDTH*CLK_DIV cycles.
REQ-018 sin changes only on the clk edge that starts a low half. sin holds its value throughout the high half.
REQ-019 sout is sampled on the clk edge that drives sclk 0->1 and shifted into the readback register MSB first.
REQ-020 Byte end: after the last bit's high half, increment byte count. If count < BYTES_PER_CHAIN go to LOAD, else go to TAIL.
REQ-021 TAIL: sclk=0, ssel=1 for CLK_DIV cycles, then go to DONE.
REQ-022 DONE: done=1 for one cycle, then go to IDLE. ssel is 0 in DONE.
REQ-023 Byte count and bit counters wrap only by explicit clear. Exactly BYTES_PER_CHAIN*BYTE_WIDTH sclk rising edges occur per transfer.
REQ-024 A command handshake in the same cycle as DONE->IDLE is impossible; cmd_ready is asserted only in IDLE.

Reset
REQ-025 rst has priority over all other inputs and is effective at the next clk edge from any state.
REQ-026 Reset values: state=IDLE; cmd_ready=1; byte_in_ready=0; busy=0; done=0; sclk=0; sin=0; ssel=0; saddr=0; byte_out=0; byte_out_valid=0; all counters 0.
REQ-027 Reset mid-transfer abandons the transfer. No done pulse and no partial byte_out_valid are produced.

Configuration
REQ-028 Macro SCAN_READBACK_EN defined: sout is captured per REQ-019. byte_out_valid pulses one cycle, on the cycle after each byte's final sout sample, with byte_out holding the captured byte until the next pulse.
REQ-029 Macro SCAN_READBACK_EN undefined: sout is ignored, byte_out=0, byte_out_valid=0 permanently. All other behaviour is identical.

Verification
REQ-030 Reset/idle: rst high 2 cycles -> all outputs at REQ-026 values, cmd_ready=1, sclk=0.
REQ-031 Write, BYTES_PER_CHAIN=2, CLK_DIV=1, cmd_addr=5, bytes 0xA5,0x3C always valid -> sin sequence at rising sclk 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; saddr=5 throughout; done 35 cycles after the cmd handshake edge; 16 sclk rising edges total.
REQ-032 Stall: byte_in_valid held low 10 cycles before the second byte -> sclk=0 and ssel=1 for the whole stall; bit stream unchanged; done delayed by exactly 10 cycles.
REQ-033 Readback (SCAN_READBACK_EN): sout driven by a 16-bit model chain preloaded 0x5AF0 -> byte_out 0x5A then 0xF0, each with a one-cycle byte_out_valid.
REQ-034 Reset mid-SHIFT at bit 3 of byte 0 -> next cycle ssel=0, sclk=0, busy=0, no done pulse. A new command is then accepted and completes normally.
REQ-035 cmd_valid held high during a transfer -> not accepted until IDLE. A second transfer starts the cycle after DONE with no extra sclk edges between transfers.

Source files
------------

// File: rtl/scan_loader.sv
// scan_loader: byte-stream to serial scan-chain master.
// A command selects a chain; BYTES_PER_CHAIN bytes are shifted out MSB first
// on sin/sclk, with CLK_DIV clk cycles per sclk half-period.
// Optional feature macro: SCAN_READBACK_EN -- when defined, sout is captured on
// every sclk rising edge and each completed byte is presented on byte_out with a
// one-cycle byte_out_valid pulse. When undefined, byte_out/byte_out_valid stay 0.
module scan_loader #(
    parameter int BYTES_PER_CHAIN = 22,
    parameter int BYTE_WIDTH      = 8,
    parameter int CLK_DIV         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_addr,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_in_valid,
    output logic                  byte_in_ready,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic                  byte_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  sin,
    output logic                  ssel,
    output logic [2:0]            saddr,
    input  logic                  sout
);

    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BITW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam int BCW  = $clog2(BYTES_PER_CHAIN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            addr_q, addr_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BITW-1:0]       bit_q, bit_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic                  high_q, high_d;
    logic                  sclk_q, sclk_d;
    logic                  sin_q, sin_d;
    logic [BYTE_WIDTH-1:0] shreg_q, shreg_d;
    logic [BYTE_WIDTH-1:0] rx_q, rx_d;
    logic [BYTE_WIDTH-1:0] bo_q, bo_d;
    logic                  bov_q, bov_d;
    logic                  div_end_s;

`ifndef SCAN_READBACK_EN
    logic                  unused_sout_s;
    assign unused_sout_s = sout;
`endif

    assign div_end_s = (div_q == DW'(CLK_DIV - 1));

    // Next-state and datapath: counters advance only inside SHIFT/TAIL and are cleared explicitly.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        high_d     = high_q;
        sclk_d     = sclk_q;
        sin_d      = sin_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        bo_d       = bo_q;
        bov_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    byte_cnt_d = '0;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sclk_d = 1'b0;
                if (byte_in_valid) begin
                    shreg_d = byte_in;
                    sin_d   = byte_in[BYTE_WIDTH-1];
                    div_d   = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (!div_end_s) begin
                    div_d = div_q + DW'(1);
                end else if (!high_q) begin
                    // End of low half: raise sclk and sample the chain output.
                    div_d  = '0;
                    high_d = 1'b1;
                    sclk_d = 1'b1;
`ifdef SCAN_READBACK_EN
                    rx_d = {rx_q[BYTE_WIDTH-2:0], sout};
                    if (bit_q == BITW'(BYTE_WIDTH - 1)) begin
                        bo_d  = {rx_q[BYTE_WIDTH-2:0], sout};
                        bov_d = 1'b1;
                    end else begin
                        bov_d = 1'b0;
                    end
`endif
                end else if (bit_q == BITW'(BYTE_WIDTH - 1)) begin
                    // End of the last bit's high half: byte finished.
                    div_d      = '0;
                    high_d     = 1'b0;
                    sclk_d     = 1'b0;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if ((byte_cnt_q + BCW'(1)) < BCW'(BYTES_PER_CHAIN)) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end else begin
                    // Start the next bit's low half; sin moves only here.
                    div_d   = '0;
                    high_d  = 1'b0;
                    sclk_d  = 1'b0;
                    bit_d   = bit_q + BITW'(1);
                    shreg_d = {shreg_q[BYTE_WIDTH-2:0], 1'b0};
                    sin_d   = shreg_q[BYTE_WIDTH-2];
                end
            end
            ST_TAIL: begin
                sclk_d = 1'b0;
                if (div_end_s) begin
                    div_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_DONE: begin
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 3'd0;
            div_q      <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            high_q     <= 1'b0;
            sclk_q     <= 1'b0;
            sin_q      <= 1'b0;
            shreg_q    <= '0;
            rx_q       <= '0;
            bo_q       <= '0;
            bov_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            high_q     <= high_d;
            sclk_q     <= sclk_d;
            sin_q      <= sin_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            bo_q       <= bo_d;
            bov_q      <= bov_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign byte_in_ready  = (state_q == ST_LOAD);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign ssel           = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_TAIL);
    assign saddr          = ssel ? addr_q : 3'd0;
    assign sclk           = sclk_q;
    assign sin            = sin_q;
    assign byte_out       = bo_q;
    assign byte_out_valid = bov_q;

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader with BYTES_PER_CHAIN=2, BYTE_WIDTH=8, CLK_DIV=1.
module tb_scan_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_in_valid = 1'b0;
    logic       byte_in_ready;
    logic [7:0] byte_out;
    logic       byte_out_valid;
    logic       busy, done, sclk, sin, ssel, sout;
    logic [2:0] saddr;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Recorded observations of the last transfer.
    int          done_k, rises, gap_wait, bov_cnt;
    logic [15:0] sin_seq;
    logic [7:0]  bov_vals [0:3];
    bit          saddr_bad, ssel_bad, ready_bad, stall_bad, bov_wide, gap_sclk_bad, bo_nonzero;
    logic        done_ssel;
    logic [2:0]  done_saddr;

    // Model scan chain: shifts sin in on sclk rise, presents its MSB on sout.
    logic [15:0] chain;
    logic        chain_load = 1'b0;
    assign sout = chain[15];

    scan_loader #(
        .BYTES_PER_CHAIN(2),
        .BYTE_WIDTH     (8),
        .CLK_DIV        (1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
        .byte_out(byte_out), .byte_out_valid(byte_out_valid),
        .busy(busy), .done(done),
        .sclk(sclk), .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout)
    );

    always #5 clk = ~clk;

    always @(posedge sclk or posedge chain_load) begin
        if (chain_load) chain <= 16'h5AF0;
        else            chain <= {chain[14:0], sin};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk_cnt++;
        if (act !== exp_v) $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        else pass_cnt++;
    endtask

    // Runs one transfer (bytes A5, 3C), optionally stalling before byte 1.
    task automatic xfer(input logic [2:0] addr, input int stall, input bit hold_cmd);
        int idx, st, k;
        logic prev_sclk, prev_bov;
        idx = 0; st = 0; k = 0; rises = 0; sin_seq = 16'd0; bov_cnt = 0;
        saddr_bad = 0; ssel_bad = 0; ready_bad = 0; stall_bad = 0; bov_wide = 0;
        gap_sclk_bad = 0; bo_nonzero = 0; done_k = -1; gap_wait = 0;
        prev_sclk = 1'b0; prev_bov = 1'b0;
        cmd_addr = addr;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && gap_wait < 50) begin
            @(negedge clk);
            if (sclk !== 1'b0) gap_sclk_bad = 1;
            gap_wait++;
        end
        @(posedge clk);
        #1;
        if (!hold_cmd) cmd_valid = 1'b0;
        while (k < 300 && done_k < 0) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                sin_seq = {sin_seq[14:0], sin};
            end
            prev_sclk = sclk;
            if (ssel === 1'b1 && saddr !== addr) saddr_bad = 1;
            if (cmd_ready !== 1'b0) ready_bad = 1;
            if (byte_out !== 8'd0) bo_nonzero = 1;
            if (byte_out_valid === 1'b1) begin
                if (bov_cnt < 4) bov_vals[bov_cnt] = byte_out;
                bov_cnt++;
                if (prev_bov === 1'b1) bov_wide = 1;
            end
            prev_bov = byte_out_valid;
            if (done === 1'b1) begin
                done_k = k;
                done_ssel = ssel;
                done_saddr = saddr;
                byte_in_valid = 1'b0;
            end else begin
                if (ssel !== 1'b1 || busy !== 1'b1) ssel_bad = 1;
                if (byte_in_ready === 1'b1) begin
                    if (sclk !== 1'b0) stall_bad = 1;
                    if (idx == 1 && st < stall) begin
                        byte_in_valid = 1'b0;
                        st++;
                    end else begin
                        byte_in_valid = 1'b1;
                        byte_in = (idx == 0) ? 8'hA5 : 8'h3C;
                        idx++;
                    end
                end else begin
                    byte_in_valid = 1'b0;
                end
            end
            k++;
        end
        byte_in_valid = 1'b0;
    endtask

    task automatic preload_chain();
        chain_load = 1'b1;
        #1;
        chain_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_byte_in_ready", {31'd0, byte_in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_sin", {31'd0, sin}, 32'd0);
        chk("rst_ssel", {31'd0, ssel}, 32'd0);
        chk("rst_saddr", {29'd0, saddr}, 32'd0);
        chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
        chk("rst_byte_out_valid", {31'd0, byte_out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        preload_chain();
        xfer(3'd5, 0, 1'b0);
        chk("write_done_latency", done_k, 32'd35);
        chk("write_sin_seq", {16'd0, sin_seq}, 32'h0000A53C);
        chk("write_sclk_rises", rises, 32'd16);
        chk("write_saddr_held", {31'd0, saddr_bad}, 32'd0);
        chk("write_ssel_busy", {31'd0, ssel_bad}, 32'd0);
        chk("write_done_ssel", {31'd0, done_ssel}, 32'd0);
        chk("write_done_saddr", {29'd0, done_saddr}, 32'd0);
        chk("write_chain_content", {16'd0, chain}, 32'h0000A53C);
`ifdef SCAN_READBACK_EN
        chk("rb_pulse_count", bov_cnt, 32'd2);
        chk("rb_byte0", {24'd0, bov_vals[0]}, 32'h5A);
        chk("rb_byte1", {24'd0, bov_vals[1]}, 32'hF0);
        chk("rb_pulse_width", {31'd0, bov_wide}, 32'd0);
`else
        chk("rb_off_pulse_count", bov_cnt, 32'd0);
        chk("rb_off_byte_out", {31'd0, bo_nonzero}, 32'd0);
`endif
        @(negedge clk);
        chk("write_idle_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic test_stall();
        preload_chain();
        xfer(3'd3, 10, 1'b0);
        chk("stall_done_latency", done_k, 32'd45);
        chk("stall_sin_seq", {16'd0, sin_seq}, 32'h0000A53C);
        chk("stall_sclk_low", {31'd0, stall_bad}, 32'd0);
        chk("stall_ssel_high", {31'd0, ssel_bad}, 32'd0);
        chk("stall_sclk_rises", rises, 32'd16);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int r, k;
        bit saw_done;
        logic prev_sclk;
        r = 0; k = 0; prev_sclk = 1'b0; saw_done = 0;
        cmd_addr = 3'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        while (k < 100 && !(r == 3 && sclk === 1'b0 && busy === 1'b1 && byte_in_ready === 1'b0)) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev_sclk === 1'b0) r++;
            prev_sclk = sclk;
            byte_in_valid = byte_in_ready;
            byte_in = 8'hA5;
            k++;
        end
        byte_in_valid = 1'b0;
        chk("mid_reached_bit3", r, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ssel", {31'd0, ssel}, 32'd0);
        chk("mid_sclk", {31'd0, sclk}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_bov", {31'd0, byte_out_valid}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1 || byte_out_valid === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        chk("mid_no_done", {31'd0, saw_done}, 32'd0);
        preload_chain();
        xfer(3'd2, 0, 1'b0);
        chk("mid_retry_latency", done_k, 32'd35);
        chk("mid_retry_seq", {16'd0, sin_seq}, 32'h0000A53C);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        xfer(3'd5, 0, 1'b1);
        chk("b2b_first_latency", done_k, 32'd35);
        chk("b2b_ready_low", {31'd0, ready_bad}, 32'd0);
        xfer(3'd6, 0, 1'b0);
        chk("b2b_gap_cycles", gap_wait, 32'd1);
        chk("b2b_gap_sclk", {31'd0, gap_sclk_bad}, 32'd0);
        chk("b2b_second_latency", done_k, 32'd35);
        chk("b2b_second_rises", rises, 32'd16);
        chk("b2b_second_saddr", {31'd0, saddr_bad}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
